// File: rtl/if_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// if_fetch_ctrl
//
// Sequencer for the instruction-fetch (IF) stage. It owns the IF stage's
// newPC / WE / W_Ins inputs. The single IMEM write port is shared between
// two users: a host loader stream, and normal fetch.
//
//   LOAD : loader words are written into IMEM, starting at word address 0.
//   RUN  : the PC advances every cycle. Stall and branch requests are
//          honoured. RUN ends when the HALT opcode is fetched.
//
// Parameters
//   IMEM_WORDS  IMEM depth in 32-bit words; a load that reaches the last word
//               without ld_last is flagged as an overflow (load_err)
//   RESET_PC    first fetch address after start
//   HALT_INS    opcode that ends RUN once it has been delivered
//
// Ports
//   CLK        in   1   clock, all state on rising edge
//   RST        in   1   asynchronous active-low reset
//   ld_valid   in   1   loader word valid
//   ld_ready   out  1   loader word accepted when ld_valid & ld_ready
//   ld_data    in   32  instruction word to write
//   ld_last    in   1   marks the final word of a load
//   start      in   1   pulse: begin fetching at RESET_PC
//   stall      in   1   downstream hold; the current PC is repeated
//   br_taken   in   1   redirect request
//   br_target  in   32  redirect address (forced to word alignment)
//   if_newPC   out  32  write address in LOAD, next PC in RUN
//   if_WE      out  1   IMEM write enable
//   if_W_Ins   out  32  IMEM write data
//   if_PC      in   32  current PC from IF
//   if_nextPC  in   32  PC+4 from IF
//   if_Ins     in   32  instruction at if_PC
//   ins_valid  out  1   ins_out/pc_out carry a real fetched instruction
//   ins_out    out  32  fetched instruction
//   pc_out     out  32  PC of the fetched instruction
//   busy       out  1   in LOAD, ARM or RUN
//   halted     out  1   in HALT
//   load_err   out  1   sticky load-overflow flag; cleared only by reset
//   fetch_cnt  out  16  instructions delivered since start, saturating
// -----------------------------------------------------------------------------
module if_fetch_ctrl #(
  parameter int unsigned IMEM_WORDS = 256,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] HALT_INS   = 32'h0000_000C
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [31:0] ld_data,
  input  logic        ld_last,
  input  logic        start,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic [31:0] if_newPC,
  output logic        if_WE,
  output logic [31:0] if_W_Ins,
  input  logic [31:0] if_PC,
  input  logic [31:0] if_nextPC,
  input  logic [31:0] if_Ins,
  output logic        ins_valid,
  output logic [31:0] ins_out,
  output logic [31:0] pc_out,
  output logic        busy,
  output logic        halted,
  output logic        load_err,
  output logic [15:0] fetch_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ARM,
    S_RUN,
    S_HALT
  } state_t;

  // Byte address of the last IMEM word. A non-final word written here
  // means the program does not fit.
  localparam logic [31:0] LAST_ADDR = 32'((IMEM_WORDS - 1) * 4);

  state_t      state_q, state_d;
  logic [31:0] wr_addr_q, wr_addr_d;
  logic [15:0] fetch_cnt_q, fetch_cnt_d;
  logic        load_err_q, load_err_d;

  logic        loadable;
  logic        accept;
  logic [31:0] addr;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: state is updated with non-blocking assignments only. All flops then
  // sample the same pre-edge values, whatever order the blocks run in.
  // The IMEM array is inside the IF stage, not here. Reset clears only these
  // control flops, so a loaded program survives a reset.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= S_IDLE;
      wr_addr_q   <= '0;
      fetch_cnt_q <= '0;
      load_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_addr_q   <= wr_addr_d;
      fetch_cnt_q <= fetch_cnt_d;
      load_err_q  <= load_err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and outputs
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default value first. Any path that
  // does not assign a signal again still gives it a value, so no latch is
  // inferred.
  always_comb begin
    state_d     = state_q;
    wr_addr_d   = wr_addr_q;
    fetch_cnt_d = fetch_cnt_q;
    load_err_d  = load_err_q;

    if_newPC    = RESET_PC;
    if_WE       = 1'b0;
    if_W_Ins    = '0;
    ins_valid   = 1'b0;
    ins_out     = '0;
    pc_out      = '0;

    // The loader is only served when the port is not in use for fetch and
    // no overflow has been recorded. The RST term keeps ld_ready low while
    // reset is asserted, even though the state already reads IDLE then.
    loadable = RST && !load_err_q &&
               (state_q == S_IDLE || state_q == S_LOAD || state_q == S_HALT);
    ld_ready = loadable;
    accept   = ld_valid && loadable;

    // A load that begins in IDLE or HALT always restarts at address 0.
    addr = (state_q == S_LOAD) ? wr_addr_q : 32'h0;

    if (accept) begin
      // A word accept takes priority over start in IDLE and HALT.
      if_WE     = 1'b1;
      if_W_Ins  = ld_data;
      if_newPC  = addr;
      wr_addr_d = addr + 32'd4;
      if (ld_last) begin
        state_d = S_IDLE;
      end else if (addr == LAST_ADDR) begin
        // The word is still written. The overflow then stops further loads
        // and runs until reset.
        load_err_d = 1'b1;
        state_d    = S_IDLE;
      end else begin
        state_d = S_LOAD;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && !load_err_q) state_d = S_ARM;
        end

        S_LOAD: begin
          // Between loader beats, keep presenting the next write address.
          if_newPC = wr_addr_q;
        end

        S_ARM: begin
          // IF latches RESET_PC this cycle, so RUN starts with if_PC = RESET_PC.
          fetch_cnt_d = '0;
          state_d     = S_RUN;
        end

        S_RUN: begin
          ins_valid = !stall;
          ins_out   = if_Ins;
          pc_out    = if_PC;

          if (br_taken) begin
            if_newPC = {br_target[31:2], 2'b00};
          end else if (stall) begin
            if_newPC = if_PC;
          end else begin
            if_newPC = if_nextPC;
          end

          if (!stall) begin
            if (fetch_cnt_q != 16'hFFFF) fetch_cnt_d = fetch_cnt_q + 16'd1;
            // The halt word is delivered before the sequencer stops. A
            // concurrent redirect means the word was not on the taken path,
            // so it is ignored.
            if (!br_taken && (if_Ins == HALT_INS)) state_d = S_HALT;
          end
        end

        S_HALT: begin
          if_newPC = if_PC;
          if (start && !load_err_q) state_d = S_ARM;
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  assign busy      = (state_q == S_LOAD) || (state_q == S_ARM) || (state_q == S_RUN);
  assign halted    = (state_q == S_HALT);
  assign load_err  = load_err_q;
  assign fetch_cnt = fetch_cnt_q;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_if_fetch_ctrl
//
// Test bench for if_fetch_ctrl. It contains three parts:
//   * A small IF-stage emulation. It holds a PC register loaded from newPC
//     every cycle, and an IMEM with a combinational read and a write port
//     driven by WE.
//   * A phase-level model of the controller. It keeps its own picture of
//     the program, the PC and the delivered count. Every negative clock edge
//     compares the DUT outputs with the model.
//   * Directed stimulus with hand-computed literal expectations. A second
//     instance with IMEM_WORDS = 4 exercises load overflow.
// -----------------------------------------------------------------------------
module tb_if_fetch_ctrl;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] HALT_INS = 32'h0000_000C;
  localparam int unsigned WORDS    = 256;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // ---------------- main DUT signals ----------------
  logic        ld_valid  = 1'b0;
  logic        ld_last   = 1'b0;
  logic [31:0] ld_data   = '0;
  logic        start     = 1'b0;
  logic        stall     = 1'b0;
  logic        br_taken  = 1'b0;
  logic [31:0] br_target = '0;
  logic        ld_ready, if_we, ins_valid, busy, halted, load_err;
  logic [31:0] if_new_pc, if_w_ins, ins_out, pc_out;
  logic [15:0] fetch_cnt;
  logic [31:0] if_next_pc, if_ins;
  logic [31:0] if_pc = '0;
  logic [31:0] imem [WORDS] = '{default: 32'h0};

  if_fetch_ctrl #(.IMEM_WORDS(WORDS), .RESET_PC(RESET_PC), .HALT_INS(HALT_INS)) u_dut (
    .CLK(clk), .RST(rst_n),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last),
    .start(start), .stall(stall), .br_taken(br_taken), .br_target(br_target),
    .if_newPC(if_new_pc), .if_WE(if_we), .if_W_Ins(if_w_ins),
    .if_PC(if_pc), .if_nextPC(if_next_pc), .if_Ins(if_ins),
    .ins_valid(ins_valid), .ins_out(ins_out), .pc_out(pc_out),
    .busy(busy), .halted(halted), .load_err(load_err), .fetch_cnt(fetch_cnt)
  );

  // IF stage emulation
  always @(posedge clk) begin
    if (if_we) imem[if_new_pc[9:2]] <= if_w_ins;
    if_pc <= if_new_pc;
  end
  assign if_ins     = imem[if_pc[9:2]];
  assign if_next_pc = if_pc + 32'd4;

  int we_cnt = 0;
  always @(posedge clk) if (if_we) we_cnt <= we_cnt + 1;

  // ---------------- overflow DUT (4-word IMEM) ----------------
  logic        o_ld_valid = 1'b0;
  logic [31:0] o_ld_data  = '0;
  logic        o_start    = 1'b0;
  logic        o_ld_ready, o_we, o_ins_valid, o_busy, o_halted, o_load_err;
  logic [31:0] o_new_pc, o_w_ins, o_ins_out, o_pc_out;
  logic [15:0] o_fetch_cnt;

  if_fetch_ctrl #(.IMEM_WORDS(4), .RESET_PC(RESET_PC), .HALT_INS(HALT_INS)) u_ovf (
    .CLK(clk), .RST(rst_n),
    .ld_valid(o_ld_valid), .ld_ready(o_ld_ready), .ld_data(o_ld_data), .ld_last(1'b0),
    .start(o_start), .stall(1'b0), .br_taken(1'b0), .br_target(32'h0),
    .if_newPC(o_new_pc), .if_WE(o_we), .if_W_Ins(o_w_ins),
    .if_PC(32'h0), .if_nextPC(32'h4), .if_Ins(32'h0),
    .ins_valid(o_ins_valid), .ins_out(o_ins_out), .pc_out(o_pc_out),
    .busy(o_busy), .halted(o_halted), .load_err(o_load_err), .fetch_cnt(o_fetch_cnt)
  );

  int o_we_cnt = 0;
  always @(posedge clk) if (o_we) o_we_cnt <= o_we_cnt + 1;

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum {P_IDLE, P_LOAD, P_ARM, P_RUN, P_HALT} phase_e;

  typedef struct packed {
    logic        ld_ready;
    logic        we;
    logic [31:0] w_ins;
    logic        pc_chk;
    logic [31:0] new_pc;
    logic        ins_valid;
    logic [31:0] ins_out;
    logic [31:0] pc_out;
    logic        busy;
    logic        halted;
    logic        load_err;
    logic [15:0] fetch_cnt;
  } exp_t;

  phase_e      m_phase = P_IDLE;
  int unsigned m_words = 0;        // words written so far in the current load
  int unsigned m_cnt   = 0;        // deliveries since start
  bit          m_err   = 1'b0;
  logic [31:0] m_pc    = RESET_PC; // PC that IF should be holding
  logic [31:0] m_prog [WORDS] = '{default: 32'h0};

  function automatic exp_t predict(
    input phase_e ph, input int unsigned words, input int unsigned cnt, input bit err,
    input logic [31:0] pc, input logic [31:0] word_at_pc, input logic rst,
    input logic vld, input logic [31:0] data, input logic stl,
    input logic br, input logic [31:0] tgt);
    exp_t e;
    bit   can_load;
    e = '0;
    can_load    = rst && !err && (ph == P_IDLE || ph == P_LOAD || ph == P_HALT);
    e.ld_ready  = can_load;
    e.busy      = (ph == P_LOAD || ph == P_ARM || ph == P_RUN);
    e.halted    = (ph == P_HALT);
    e.load_err  = err;
    e.fetch_cnt = 16'(cnt);
    e.new_pc    = RESET_PC;
    if (!rst) begin
      e.pc_chk = 1'b1;
    end else if (can_load && vld) begin
      e.we     = 1'b1;
      e.w_ins  = data;
      e.pc_chk = 1'b1;
      e.new_pc = (ph == P_LOAD) ? 32'(words * 4) : 32'h0;
    end else if (ph == P_ARM) begin
      e.pc_chk = 1'b1;
    end else if (ph == P_RUN) begin
      e.ins_valid = !stl;
      e.ins_out   = word_at_pc;
      e.pc_out    = pc;
      e.pc_chk    = 1'b1;
      e.new_pc    = br ? (tgt & ~32'h3) : (stl ? pc : pc + 32'd4);
    end else if (ph == P_HALT) begin
      e.pc_chk = 1'b1;
      e.new_pc = pc;
    end
    return e;
  endfunction

  exp_t cur;
  assign cur = predict(m_phase, m_words, m_cnt, m_err, m_pc, m_prog[m_pc[9:2]], rst_n,
                       ld_valid, ld_data, stall, br_taken, br_target);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= P_IDLE;
      m_words <= 0;
      m_cnt   <= 0;
      m_err   <= 1'b0;
    end else if (cur.we) begin
      m_prog[cur.new_pc[9:2]] <= ld_data;
      m_words <= ((m_phase == P_LOAD) ? m_words : 0) + 1;
      if (ld_last) m_phase <= P_IDLE;
      else if (((m_phase == P_LOAD) ? m_words : 0) + 1 == WORDS) begin
        m_err   <= 1'b1;
        m_phase <= P_IDLE;
      end else m_phase <= P_LOAD;
    end else begin
      case (m_phase)
        P_IDLE, P_HALT: if (start && !m_err) m_phase <= P_ARM;
        P_ARM: begin
          m_cnt   <= 0;
          m_pc    <= RESET_PC;
          m_phase <= P_RUN;
        end
        P_RUN: begin
          m_pc <= cur.new_pc;
          if (cur.ins_valid) begin
            m_cnt <= (m_cnt >= 65535) ? 65535 : m_cnt + 1;
            if (!br_taken && cur.ins_out == HALT_INS) m_phase <= P_HALT;
          end
        end
        default: ;
      endcase
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("ld_ready", 32'(ld_ready), 32'(cur.ld_ready));
    check("if_WE", 32'(if_we), 32'(cur.we));
    if (cur.we) check("if_W_Ins", if_w_ins, cur.w_ins);
    if (cur.pc_chk) check("if_newPC", if_new_pc, cur.new_pc);
    check("ins_valid", 32'(ins_valid), 32'(cur.ins_valid));
    if (cur.ins_valid) begin
      check("ins_out", ins_out, cur.ins_out);
      check("pc_out", pc_out, cur.pc_out);
    end
    check("busy", 32'(busy), 32'(cur.busy));
    check("halted", 32'(halted), 32'(cur.halted));
    check("load_err", 32'(load_err), 32'(cur.load_err));
    check("fetch_cnt", 32'(fetch_cnt), 32'(cur.fetch_cnt));
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic load_word(input logic [31:0] data, input logic last);
    ld_valid = 1'b1;
    ld_data  = data;
    ld_last  = last;
  endtask

  logic [31:0] prog [4];
  int          we_base;

  initial begin
    prog[0] = 32'h2001_0005;
    prog[1] = 32'h2002_0007;
    prog[2] = 32'h0022_1820;
    prog[3] = 32'h0000_000C;

    // ---- reset ----
    #1 rst_n = 1'b0;
    settle();
    check("rst if_WE", 32'(if_we), 32'h0);
    check("rst ld_ready", 32'(ld_ready), 32'h0);
    check("rst if_newPC", if_new_pc, RESET_PC);
    check("rst ins_valid", 32'(ins_valid), 32'h0);
    step();
    step();
    rst_n = 1'b1;

    // ---- load 3 words ----
    we_base = we_cnt;
    for (int i = 0; i < 3; i++) begin
      load_word(prog[i], i == 2);
      settle();
      check("load if_WE", 32'(if_we), 32'h1);
      check("load addr", if_new_pc, 32'(i * 4));
      step();
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    settle();
    check("load we count", 32'(we_cnt - we_base), 32'd3);
    check("load idle busy", 32'(busy), 32'h0);

    // ---- run: first fetches, stall, branch ----
    start = 1'b1;
    step();
    start = 1'b0;
    settle();
    check("arm ins_valid", 32'(ins_valid), 32'h0);
    check("arm busy", 32'(busy), 32'h1);
    step();
    settle();
    check("run0 ins_valid", 32'(ins_valid), 32'h1);
    check("run0 pc_out", pc_out, 32'h0);
    check("run0 ins_out", ins_out, 32'h2001_0005);
    step();
    stall = 1'b1;
    settle();
    check("stall1 pc_out", pc_out, 32'h4);
    check("stall1 ins_valid", 32'(ins_valid), 32'h0);
    step();
    settle();
    check("stall2 pc_out", pc_out, 32'h4);
    check("stall2 ins_valid", 32'(ins_valid), 32'h0);
    check("stall2 fetch_cnt", 32'(fetch_cnt), 32'd1);
    step();
    stall = 1'b0;
    settle();
    check("resume pc_out", pc_out, 32'h4);
    check("resume ins_valid", 32'(ins_valid), 32'h1);
    step();
    br_taken  = 1'b1;
    br_target = 32'h0000_000E;
    settle();
    check("br pc_out", pc_out, 32'h8);
    check("br newPC", if_new_pc, 32'h0000_000C);
    step();
    br_target = 32'h0;
    stall     = 1'b1;
    settle();
    check("br target pc_out", pc_out, 32'h0000_000C);
    check("br+stall ins_valid", 32'(ins_valid), 32'h0);
    check("br+stall newPC", if_new_pc, 32'h0);
    step();
    br_taken = 1'b0;
    stall    = 1'b0;
    settle();
    check("redirect pc_out", pc_out, 32'h0);
    check("redirect fetch_cnt", 32'(fetch_cnt), 32'd3);

    // ---- reset pulse mid-RUN ----
    rst_n = 1'b0;
    #1;
    check("midrst if_WE", 32'(if_we), 32'h0);
    check("midrst ins_valid", 32'(ins_valid), 32'h0);
    step();
    rst_n = 1'b1;
    settle();
    check("postrst busy", 32'(busy), 32'h0);
    check("postrst fetch_cnt", 32'(fetch_cnt), 32'h0);
    step();

    // ---- load 4 words incl. halt, with an ignored start in LOAD ----
    load_word(prog[0], 1'b0);
    step();
    ld_valid = 1'b0;
    start    = 1'b1;
    settle();
    check("load start ignored busy", 32'(busy), 32'h1);
    step();
    start = 1'b0;
    for (int i = 1; i < 4; i++) begin
      load_word(prog[i], i == 3);
      step();
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    start    = 1'b1;
    step();                     // ARM
    start = 1'b0;
    step();                     // PC 0
    step();                     // PC 4
    step();                     // PC 8
    step();                     // PC C
    settle();
    check("halt word valid", 32'(ins_valid), 32'h1);
    check("halt word ins", ins_out, 32'h0000_000C);
    step();
    settle();
    check("halted", 32'(halted), 32'h1);
    check("halted ins_valid", 32'(ins_valid), 32'h0);
    check("halted fetch_cnt", 32'(fetch_cnt), 32'd4);
    check("halted newPC", if_new_pc, 32'h10);

    // ---- rerun ----
    start = 1'b1;
    step();                     // ARM
    start = 1'b0;
    step();                     // PC 0
    settle();
    check("rerun pc_out", pc_out, 32'h0);
    check("rerun cnt0", 32'(fetch_cnt), 32'd0);
    step();                     // PC 4
    settle();
    check("rerun cnt1", 32'(fetch_cnt), 32'd1);
    step();                     // PC 8
    step();                     // PC C
    step();                     // HALT
    settle();
    check("rehalt", 32'(halted), 32'h1);

    // ---- word accept in HALT beats start ----
    load_word(prog[0], 1'b1);
    start = 1'b1;
    settle();
    check("halt accept WE", 32'(if_we), 32'h1);
    check("halt accept addr", if_new_pc, 32'h0);
    step();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    start    = 1'b0;
    settle();
    check("halt accept busy", 32'(busy), 32'h0);
    check("halt accept halted", 32'(halted), 32'h0);
    step();

    // ---- overflow on the 4-word instance ----
    for (int i = 0; i < 5; i++) begin
      o_ld_valid = 1'b1;
      o_ld_data  = 32'hA000_0000 + 32'(i);
      settle();
      check("ovf ld_ready", 32'(o_ld_ready), 32'(i < 4));
      check("ovf WE", 32'(o_we), 32'(i < 4));
      if (i < 4) check("ovf addr", o_new_pc, 32'(i * 4));
      step();
    end
    o_ld_valid = 1'b0;
    settle();
    check("ovf load_err", 32'(o_load_err), 32'h1);
    check("ovf ld_ready after", 32'(o_ld_ready), 32'h0);
    check("ovf write count", 32'(o_we_cnt), 32'd4);
    o_start = 1'b1;
    step();
    o_start = 1'b0;
    settle();
    check("ovf start ignored", 32'(o_busy), 32'h0);
    check("ovf ins_valid", 32'(o_ins_valid), 32'h0);
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

endmodule
